// File: rtl/aes_pkg.sv
// Shared AES key-schedule definitions: widths, controller states, Rcon helpers.
package aes_pkg;
  localparam int KW = 128;
  localparam int NR = 10;
  localparam logic [3:0] LAST_ROUND = 4'(NR);
  localparam logic [7:0] RCON_INIT = 8'h01;

  typedef logic [KW-1:0] rkey_t;
  typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;

  // Multiply by x in GF(2^8) with the AES polynomial.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction
endpackage

// File: rtl/aes_sbox.sv
// AES forward S-box: GF(2^8) inverse (x^254) followed by the affine transform.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] a,
  output logic [7:0] y
);
  function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] z);
    logic [7:0] p;
    logic [7:0] acc;
    acc = '0;
    p   = x;
    for (int i = 0; i < 8; i++) begin
      if (z[i]) acc ^= p;
      p = xtime(p);
    end
    return acc;
  endfunction

  logic [7:0] inv;
  logic [7:0] pw;

  // x^254 = prod of x^(2^k), k=1..7; zero maps to zero naturally.
  always_comb begin
    pw  = a;
    inv = 8'h01;
    for (int k = 1; k < 8; k++) begin
      pw  = gmul(pw, pw);
      inv = gmul(inv, pw);
    end
  end

  assign y = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
           ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
endmodule

// File: rtl/key_round_step.sv
// One AES-128 key-expansion step: RotWord, SubWord, Rcon, then the word chain.
module key_round_step
  import aes_pkg::*;
#(
  parameter int NUM_LANES = 4
) (
  input  rkey_t      prev,
  input  logic [7:0] rcon,
  output rkey_t      next
);
  logic [31:0] w0, w1, w2, w3, t, n0, n1, n2, n3;
  logic [NUM_LANES-1:0][7:0] rot_b, sub_b;

  assign {w0, w1, w2, w3} = prev;
  assign rot_b = {w3[23:0], w3[31:24]};

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_sb
    aes_sbox u_sbox (.a(rot_b[g]), .y(sub_b[g]));
  end

  assign t  = sub_b ^ {rcon, 24'h0};
  assign n0 = w0 ^ t;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;
  assign next = {n0, n1, n2, n3};
endmodule

// File: rtl/aes_key_schedule_ctrl.sv
// AES-128 key-schedule sequencer: expands one round key per clock into a
// register file readable by index. Optional KEYSCHED_STREAM_EN adds a
// registered stream of every storage write (rk_out / rk_out_idx / rk_out_valid).
module aes_key_schedule_ctrl
  import aes_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [KW-1:0] key_in,
  output logic          busy,
  output logic          done,
  output logic          keys_valid,
  input  logic [3:0]    rd_idx,
  output logic [KW-1:0] rd_key
`ifdef KEYSCHED_STREAM_EN
  ,
  output logic [KW-1:0] rk_out,
  output logic [3:0]    rk_out_idx,
  output logic          rk_out_valid
`endif
);
  state_t     state_q, state_d;
  logic [3:0] round_q, prev_idx;
  logic [7:0] rcon_q;
  rkey_t      rk [NR+1];
  rkey_t      prev_key, step_key;
  logic       accept, expand;

  assign accept   = (state_q == IDLE) && start;
  assign expand   = (state_q == EXPAND);
  assign prev_idx = round_q - 4'd1;
  assign prev_key = (prev_idx <= LAST_ROUND) ? rk[prev_idx] : '0;

  key_round_step u_step (.prev(prev_key), .rcon(rcon_q), .next(step_key));

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state: DONE lasts one cycle and never samples start.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = EXPAND;
      EXPAND:  if (round_q == LAST_ROUND) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Status outputs decoded from state.
  always_comb begin
    busy = (state_q == EXPAND) || (state_q == DONE);
    done = (state_q == DONE);
  end

  // Round counter, Rcon and key storage; round saturates at NR.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      round_q    <= '0;
      rcon_q     <= RCON_INIT;
      keys_valid <= 1'b0;
      for (int i = 0; i <= NR; i++) rk[i] <= '0;
    end else if (accept) begin
      rk[0]      <= key_in;
      round_q    <= 4'd1;
      rcon_q     <= RCON_INIT;
      keys_valid <= 1'b0;
    end else if (expand) begin
      rk[round_q] <= step_key;
      rcon_q      <= xtime(rcon_q);
      if (round_q == LAST_ROUND) keys_valid <= 1'b1;
      else                       round_q    <= round_q + 4'd1;
    end
  end

  // Index read; out-of-range indices return zero.
  always_comb begin
    rd_key = '0;
    if (rd_idx <= LAST_ROUND) rd_key = rk[rd_idx];
  end

`ifdef KEYSCHED_STREAM_EN
  // Mirror each storage write one cycle later.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rk_out       <= '0;
      rk_out_idx   <= '0;
      rk_out_valid <= 1'b0;
    end else if (accept) begin
      rk_out       <= key_in;
      rk_out_idx   <= 4'd0;
      rk_out_valid <= 1'b1;
    end else if (expand) begin
      rk_out       <= step_key;
      rk_out_idx   <= round_q;
      rk_out_valid <= 1'b1;
    end else begin
      rk_out_valid <= 1'b0;
    end
  end
`endif
endmodule

// File: tb/tb_aes_key_schedule_ctrl.sv
// Directed bench for aes_key_schedule_ctrl using FIPS-197 key-expansion vectors.
module tb_aes_key_schedule_ctrl;
  localparam logic [127:0] K1     = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] K1_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] K1_R2  = 128'hf2c295f27a96b9435935807a7359f67f;
  localparam logic [127:0] K1_R3  = 128'h3d80477d4716fe3e1e237e446d7a883b;
  localparam logic [127:0] K1_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] K2     = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] K2_R10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic [127:0] key_in = '0;
  logic         busy, done, keys_valid;
  logic [3:0]   rd_idx = '0;
  logic [127:0] rd_key;
  int checks = 0;
  int errors = 0;

`ifdef KEYSCHED_STREAM_EN
  logic [127:0] rk_out;
  logic [3:0]   rk_out_idx;
  logic         rk_out_valid;
  logic [3:0]   sq_idx[$];
  logic [127:0] sq_val[$];
`endif

  aes_key_schedule_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .key_in(key_in),
    .busy(busy), .done(done), .keys_valid(keys_valid),
    .rd_idx(rd_idx), .rd_key(rd_key)
`ifdef KEYSCHED_STREAM_EN
    , .rk_out(rk_out), .rk_out_idx(rk_out_idx), .rk_out_valid(rk_out_valid)
`endif
  );

  always #5 clk = ~clk;

`ifdef KEYSCHED_STREAM_EN
  always @(negedge clk) begin
    if (rk_out_valid === 1'b1) begin
      sq_idx.push_back(rk_out_idx);
      sq_val.push_back(rk_out);
    end
  end
`endif

  task automatic accept(input logic [127:0] k);
    @(negedge clk);
    key_in = k;
    start  = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Returns the negedge count (after the accept edge) at which done is seen; -1 on timeout.
  task automatic wait_done(output int cyc);
    cyc = -1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    #1 reset = 1'b1;
    #2;
    checks++; if ({busy, done, keys_valid} !== 3'b000) begin errors++; $display("FAIL reset_status got %b exp 000", {busy, done, keys_valid}); end
    for (int i = 0; i < 16; i++) begin
      rd_idx = 4'(i); #1;
      checks++; if (rd_key !== '0) begin errors++; $display("FAIL reset_rd%0d got %h exp 0", i, rd_key); end
    end
    @(negedge clk) reset = 1'b0;
    accept(K1);
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midrun_busy got %b exp 1", busy); end
    reset = 1'b1;
    #1;
    checks++; if ({busy, done, keys_valid} !== 3'b000) begin errors++; $display("FAIL midrun_reset_status got %b exp 000", {busy, done, keys_valid}); end
    for (int i = 0; i < 16; i++) begin
      rd_idx = 4'(i); #1;
      checks++; if (rd_key !== '0) begin errors++; $display("FAIL midrun_reset_rd%0d got %h exp 0", i, rd_key); end
    end
    @(negedge clk) reset = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL post_reset_busy got %b exp 0", busy); end
  endtask

  task automatic test_expand();
    int cyc;
    accept(K1);
    wait_done(cyc);
    checks++; if (cyc !== 11) begin errors++; $display("FAIL expand_latency got %0d exp 11", cyc); end
    checks++; if ({busy, keys_valid} !== 2'b11) begin errors++; $display("FAIL expand_done_status got %b exp 11", {busy, keys_valid}); end
    rd_idx = 4'd1;  #1;
    checks++; if (rd_key !== K1_R1) begin errors++; $display("FAIL expand_rk1 got %h exp %h", rd_key, K1_R1); end
    rd_idx = 4'd2;  #1;
    checks++; if (rd_key !== K1_R2) begin errors++; $display("FAIL expand_rk2 got %h exp %h", rd_key, K1_R2); end
    rd_idx = 4'd3;  #1;
    checks++; if (rd_key !== K1_R3) begin errors++; $display("FAIL expand_rk3 got %h exp %h", rd_key, K1_R3); end
    rd_idx = 4'd10; #1;
    checks++; if (rd_key !== K1_R10) begin errors++; $display("FAIL expand_rk10 got %h exp %h", rd_key, K1_R10); end
    @(negedge clk);
    checks++; if ({busy, done, keys_valid} !== 3'b001) begin errors++; $display("FAIL expand_idle_status got %b exp 001", {busy, done, keys_valid}); end
  endtask

  task automatic test_start_ignored();
    int pulses = 0;
    accept(K1);
    repeat (5) @(negedge clk);
    start = 1'b1; key_in = K2;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done === 1'b1) pulses++;
    end
    checks++; if (pulses !== 1) begin errors++; $display("FAIL ignored_done_pulses got %0d exp 1", pulses); end
    rd_idx = 4'd10; #1;
    checks++; if (rd_key !== K1_R10) begin errors++; $display("FAIL ignored_rk10 got %h exp %h", rd_key, K1_R10); end
    rd_idx = 4'd0; #1;
    checks++; if (rd_key !== K1) begin errors++; $display("FAIL ignored_rk0 got %h exp %h", rd_key, K1); end
  endtask

  task automatic test_back_to_back();
    int cyc;
    @(negedge clk);
    key_in = K2; start = 1'b1;
    #1;
    checks++; if (keys_valid !== 1'b1) begin errors++; $display("FAIL b2b_kv_before got %b exp 1", keys_valid); end
    @(posedge clk);
    #1 start = 1'b0;
    checks++; if ({busy, keys_valid} !== 2'b10) begin errors++; $display("FAIL b2b_after_accept got %b exp 10", {busy, keys_valid}); end
    wait_done(cyc);
    checks++; if (cyc !== 11) begin errors++; $display("FAIL b2b_latency got %0d exp 11", cyc); end
    rd_idx = 4'd10; #1;
    checks++; if (rd_key !== K2_R10) begin errors++; $display("FAIL b2b_rk10 got %h exp %h", rd_key, K2_R10); end
  endtask

  task automatic test_rd_range();
    for (int i = 11; i < 16; i++) begin
      rd_idx = 4'(i); #1;
      checks++; if (rd_key !== '0) begin errors++; $display("FAIL range_rd%0d got %h exp 0", i, rd_key); end
    end
    rd_idx = 4'd0; #1;
    checks++; if (rd_key !== K2) begin errors++; $display("FAIL range_rd0 got %h exp %h", rd_key, K2); end
  endtask

  task automatic test_held_start();
    int cyc;
    @(negedge clk);
    key_in = K1; start = 1'b1;
    @(posedge clk);
    repeat (11) @(posedge clk);
    #1;
    checks++; if ({busy, keys_valid} !== 2'b01) begin errors++; $display("FAIL held_after_done got %b exp 01", {busy, keys_valid}); end
    @(posedge clk);
    #1 start = 1'b0;
    checks++; if ({busy, keys_valid} !== 2'b10) begin errors++; $display("FAIL held_retrigger got %b exp 10", {busy, keys_valid}); end
    wait_done(cyc);
    checks++; if (cyc !== 11) begin errors++; $display("FAIL held_latency got %0d exp 11", cyc); end
    rd_idx = 4'd10; #1;
    checks++; if (rd_key !== K1_R10) begin errors++; $display("FAIL held_rk10 got %h exp %h", rd_key, K1_R10); end
    @(negedge clk);
  endtask

`ifdef KEYSCHED_STREAM_EN
  task automatic test_stream();
    int cyc;
    logic [127:0] expv [5];
    int           expi [5];
    expv = '{K1, K1_R1, K1_R2, K1_R3, K1_R10};
    expi = '{0, 1, 2, 3, 10};
    @(negedge clk);
    sq_idx.delete();
    sq_val.delete();
    accept(K1);
    wait_done(cyc);
    repeat (2) @(negedge clk);
    checks++; if (sq_idx.size() !== 11) begin errors++; $display("FAIL stream_count got %0d exp 11", sq_idx.size()); end
    for (int i = 0; i < 11 && i < sq_idx.size(); i++) begin
      checks++; if (sq_idx[i] !== 4'(i)) begin errors++; $display("FAIL stream_idx%0d got %0d exp %0d", i, sq_idx[i], i); end
    end
    for (int j = 0; j < 5; j++) begin
      if (expi[j] < sq_val.size()) begin
        checks++; if (sq_val[expi[j]] !== expv[j]) begin errors++; $display("FAIL stream_val%0d got %h exp %h", expi[j], sq_val[expi[j]], expv[j]); end
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_expand();
    test_start_ignored();
    test_back_to_back();
    test_rd_range();
    test_held_start();
`ifdef KEYSCHED_STREAM_EN
    test_stream();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
